// File: rtl/field_separator_buf.sv
// Buffered MIPS field separator: decodes instructions on push and queues the decoded entries in a DEPTH-entry FIFO.
// Optional performance counters (instr_cnt, stall_cnt) are enabled by defining FIELD_SEP_PERF_EN.
module field_separator_buf #(
  parameter int DEPTH    = 2,
  parameter int DATA_W   = 32,
  parameter int LINK_REG = 31
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                instr,
  input  logic [1:0]                 RegDst,
  input  logic                       ExtSel,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [5:0]                 op_out,
  output logic [4:0]                 rs_out,
  output logic [4:0]                 rt_out,
  output logic [4:0]                 rd_out,
  output logic [4:0]                 shamt_out,
  output logic [5:0]                 funct_out,
  output logic [DATA_W-1:0]          imm_out,
  output logic [25:0]                target_out,
  output logic [$clog2(DEPTH):0]     count
`ifdef FIELD_SEP_PERF_EN
  ,
  output logic [31:0]                instr_cnt,
  output logic [31:0]                stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [4:0] LINK = 5'(LINK_REG);

  typedef struct packed {
    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [DATA_W-1:0] imm;
    logic [25:0]       target;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          din;
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    din        = '0;
    din.op     = instr[31:26];
    din.rs     = instr[25:21];
    din.rt     = instr[20:16];
    din.shamt  = instr[10:6];
    din.funct  = instr[5:0];
    din.target = instr[25:0];
    din.imm    = ExtSel ? DATA_W'($signed(instr[15:0])) : DATA_W'(instr[15:0]);
    case (RegDst)
      2'b01:   din.rd = instr[15:11];
      2'b10:   din.rd = LINK;
      default: din.rd = instr[20:16];  // 2'b11 is reserved and decodes as rt
    endcase
  end

  assign out_valid = (count != '0);
  assign in_ready  = (count != CW'(DEPTH)) && !reset && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush && !reset;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count gates every read, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_comb begin
    head       = out_valid ? mem[rd_ptr] : '0;
    op_out     = head.op;
    rs_out     = head.rs;
    rt_out     = head.rt;
    rd_out     = head.rd;
    shamt_out  = head.shamt;
    funct_out  = head.funct;
    imm_out    = head.imm;
    target_out = head.target;
  end

`ifdef FIELD_SEP_PERF_EN
  // Counters survive flush and wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (push)                  instr_cnt <= instr_cnt + 32'd1;
      if (in_valid && !in_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_field_separator_buf.sv
// Self-checking bench for field_separator_buf: directed vector table, FIFO corner sequences and randomized traffic.
// The reference model is a queue of decoded entries built from the instruction-format rules.
module tb_field_separator_buf;

  localparam int DEPTH  = 2;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, ExtSel, flush, out_valid, out_ready;
  logic [31:0] instr;
  logic [1:0]  RegDst;
  logic [5:0]  op_out, funct_out;
  logic [4:0]  rs_out, rt_out, rd_out, shamt_out;
  logic [DATA_W-1:0] imm_out;
  logic [25:0] target_out;
  logic [$clog2(DEPTH):0] count;
`ifdef FIELD_SEP_PERF_EN
  logic [31:0] instr_cnt, stall_cnt;
`endif

  field_separator_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W), .LINK_REG(31)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .RegDst(RegDst), .ExtSel(ExtSel), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_out(op_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
    .shamt_out(shamt_out), .funct_out(funct_out), .imm_out(imm_out),
    .target_out(target_out), .count(count)
`ifdef FIELD_SEP_PERF_EN
    , .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned op, rs, rt, rd, shamt, funct, imm, target;
  } model_t;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  regdst;
    bit          extsel;
    int unsigned op, rs, rt, rd, funct, imm, target;
  } vec_t;

  model_t      q[$];
  int          checks = 0;
  int          failures = 0;
  longint      m_pushes = 0;
  longint      m_stalls = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic model_t model_decode(input logic [31:0] w, input logic [1:0] rdst, input bit ext);
    model_t m;
    int unsigned u = w;
    m.op     = u >> 26;
    m.rs     = (u >> 21) % 32;
    m.rt     = (u >> 16) % 32;
    m.shamt  = (u >> 6) % 32;
    m.funct  = u % 64;
    m.target = u % (1 << 26);
    m.imm    = u % 65536;
    if (ext && m.imm >= 32768) m.imm = m.imm + 32'hFFFF0000;
    if (rdst == 2'd1)      m.rd = (u >> 11) % 32;
    else if (rdst == 2'd2) m.rd = 31;
    else                   m.rd = m.rt;
    return m;
  endfunction

  task automatic compare_outputs();
    model_t e = '{default: 0};
    if (q.size() > 0) e = q[0];
    check("out_valid", out_valid, q.size() > 0);
    check("count", count, q.size());
    check("op_out", op_out, e.op);
    check("rs_out", rs_out, e.rs);
    check("rt_out", rt_out, e.rt);
    check("rd_out", rd_out, e.rd);
    check("shamt_out", shamt_out, e.shamt);
    check("funct_out", funct_out, e.funct);
    check("imm_out", imm_out, e.imm);
    check("target_out", target_out, e.target);
`ifdef FIELD_SEP_PERF_EN
    check("instr_cnt", instr_cnt, m_pushes % 64'h1_0000_0000);
    check("stall_cnt", stall_cnt, m_stalls % 64'h1_0000_0000);
`endif
  endtask

  // One clock cycle: drive at posedge+1, check in_ready mid-cycle, then check state after the edge.
  task automatic cycle(input bit iv, input logic [31:0] ins, input logic [1:0] rdst, input bit es,
                       input bit ordy, input bit fl, input bit rst);
    bit exp_ready, do_push, do_pop;
    in_valid = iv; instr = ins; RegDst = rdst; ExtSel = es;
    out_ready = ordy; flush = fl; reset = rst;
    exp_ready = (q.size() < DEPTH) && !fl && !rst;
    #3;
    check("in_ready", in_ready, exp_ready);
    do_push = iv && exp_ready;
    do_pop  = (q.size() > 0) && ordy && !fl && !rst;
    if (rst) begin
      m_pushes = 0;
      m_stalls = 0;
    end else begin
      if (do_push) m_pushes++;
      if (iv && !exp_ready) m_stalls++;
    end
    @(posedge clk);
    if (rst || fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(model_decode(ins, rdst, es));
    end
    #1;
    compare_outputs();
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{32'h00221820, 2'b01, 1'b0, 0,    1,  2, 3,  6'h20, 32'h00001820, 26'h0221820};
    vecs[1] = '{32'h8FA8FFFC, 2'b00, 1'b1, 6'h23, 29, 8, 8,  6'h3C, 32'hFFFFFFFC, 26'h3A8FFFC};
    vecs[2] = '{32'h3421FFFF, 2'b00, 1'b0, 6'h0D, 1,  1, 1,  6'h3F, 32'h0000FFFF, 26'h021FFFF};
    vecs[3] = '{32'h0C000010, 2'b10, 1'b0, 3,    0,  0, 31, 6'h10, 32'h00000010, 26'h0000010};
    vecs[4] = '{32'h00221820, 2'b11, 1'b1, 0,    1,  2, 2,  6'h20, 32'h00001820, 26'h0221820};

    in_valid = 0; instr = 0; RegDst = 0; ExtSel = 0; out_ready = 0; flush = 0; reset = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_imm", imm_out, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("post_rst_in_ready", in_ready, 1);

    // Directed decode table: push into an empty buffer, check the head, then pop it.
    for (int i = 0; i < 5; i++) begin
      cycle(1, vecs[i].instr, vecs[i].regdst, vecs[i].extsel, 0, 0, 0);
      check("vec_valid", out_valid, 1);
      check("vec_op", op_out, vecs[i].op);
      check("vec_rs", rs_out, vecs[i].rs);
      check("vec_rt", rt_out, vecs[i].rt);
      check("vec_rd", rd_out, vecs[i].rd);
      check("vec_funct", funct_out, vecs[i].funct);
      check("vec_imm", imm_out, vecs[i].imm);
      check("vec_target", target_out, vecs[i].target);
      cycle(0, 0, 0, 0, 1, 0, 0);
      check("vec_popped", count, 0);
    end

    // Full buffer back-pressure and ordering.
    cycle(1, 32'h00000001, 2'b00, 0, 0, 0, 0);
    cycle(1, 32'h00000002, 2'b00, 0, 0, 0, 0);
    check("full_count", count, 2);
    cycle(1, 32'h00000003, 2'b00, 0, 1, 0, 0);
    check("full_pop_count", count, 1);
    check("full_head_b", funct_out, 2);
    cycle(1, 32'h00000003, 2'b00, 0, 0, 0, 0);
    check("third_accepted", count, 2);
    cycle(0, 0, 0, 0, 1, 0, 0);
    check("order_c", funct_out, 3);

    // Flush with simultaneous push and pop.
    cycle(1, 32'h00000004, 2'b00, 0, 0, 0, 0);
    check("pre_flush_count", count, 2);
    cycle(1, 32'h00000005, 2'b00, 0, 1, 1, 0);
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 0);
    check("flush_funct", funct_out, 0);

    // Steady push+pop at occupancy one.
    cycle(1, 32'h00000010, 2'b00, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      cycle(1, 32'h00000010 + k, 2'b00, 0, 1, 0, 0);
      check("steady_count", count, 1);
      check("steady_head", funct_out, 6'((16 + k) % 64));
    end
`ifdef FIELD_SEP_PERF_EN
    check("steady_instr_cnt", instr_cnt, m_pushes);
`endif

    // Reset mid-operation drops entries.
    cycle(1, 32'h00000020, 2'b00, 0, 0, 0, 0);
    cycle(1, 32'h00000021, 2'b00, 0, 0, 0, 1);
    check("midrst_count", count, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 9) < 7, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/field_separator_buf.md
Name: field_separator_buf

Overview:
Parametrised successor to the combinational MIPS field separator: a buffered decode stage between instruction fetch and the register file/control.
- Accepts 32-bit instructions over a valid/ready handshake, splits them into fields and resolves the destination register.
- Destination is rt, rd or the link register, selected per instruction by a 2-bit RegDst.
- Immediate is sign- or zero-extended.
- Decoded entries are held in a DEPTH-entry FIFO so fetch and decode can stall independently; supports pipeline flush.

Parameters:
DEPTH, 2, FIFO entries; power of two, >= 2
DATA_W, 32, extended-immediate output width; >= 16
LINK_REG, 31, register index driven on rd_out when RegDst = 2'b10 (jal)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  instr/RegDst/ExtSel valid this cycle
in_ready  out  1  buffer can accept (push = in_valid & in_ready)
instr  in  32  raw instruction word
RegDst  in  2  00 rt, 01 rd, 10 LINK_REG, 11 reserved (treated as 00)
ExtSel  in  1  1 sign-extend imm, 0 zero-extend
flush  in  1  discard all buffered entries
out_valid  out  1  head entry valid
out_ready  in  1  consumer takes head (pop = out_valid & out_ready)
op_out  out  6  instr[31:26] of head
rs_out  out  5  instr[25:21]
rt_out  out  5  instr[20:16]
rd_out  out  5  resolved destination register
shamt_out  out  5  instr[10:6]
funct_out  out  6  instr[5:0]
imm_out  out  DATA_W  instr[15:0] extended per ExtSel
target_out  out  26  instr[25:0]
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Decode (field slicing, RegDst mux, extension) is combinational on push; the decoded entry is stored, so the inputs need only be valid in the push cycle.
- Storage: circular buffer with wr_ptr and rd_ptr ($clog2(DEPTH) bits, natural wrap at DEPTH) and a count register.
- in_ready = (count != DEPTH) & ~reset & ~flush. out_valid = (count != 0).
- Latency: an entry pushed at edge N is visible on the outputs (out_valid=1) after edge N. There is no same-cycle input-to-output bypass.
- Field outputs show the head entry when out_valid=1 and are forced to all-zero when out_valid=0.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full (count == DEPTH): in_ready=0, so no push can occur. A pop in this cycle makes in_ready=1 in the next cycle; full-cycle push-through is not supported.
- Empty: out_valid=0, so out_ready is ignored and no pop occurs.
- flush=1: at the next edge count, wr_ptr and rd_ptr all become 0, and any push or pop in that cycle is discarded. in_ready is 0 during the flush cycle. Flush has priority over push and pop.
- reset=1 at the edge: count, wr_ptr and rd_ptr become 0. The storage array is not cleared.
  - Reset values: out_valid=0, all field outputs 0, count=0.
  - in_ready=0 while reset is asserted and 1 in the first cycle after release.
  - Reset mid-operation drops all entries, identically to flush.
- Extension: sign mode replicates instr[15] into bits DATA_W-1:16; zero mode fills them with 0.
- RegDst=11 decodes as rt and is not flagged.

Optional Feature:
FIELD_SEP_PERF_EN
- Defined: adds output ports instr_cnt (32 bits, increments on each push) and stall_cnt (32 bits, increments each cycle with in_valid=1 & in_ready=0).
  - Both clear on reset; flush does not clear them.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
1. After reset, push instr=0x00221820 (add $3,$1,$2), RegDst=01 -> next cycle: out_valid=1, op=0, rs=1, rt=2, rd_out=3, shamt=0, funct=0x20, count=1.
2. Push 0x8FA8FFFC (lw $8,-4($29)), RegDst=00, ExtSel=1 -> op=0x23, rs=29, rd_out=8, imm_out=0xFFFFFFFC. Then push 0x3421FFFF (ori), ExtSel=0 -> imm_out=0x0000FFFF.
3. Push 0x0C000010 (jal), RegDst=10 -> op=3, target_out=0x0000010, rd_out=31.
4. DEPTH=2, out_ready=0, push three instructions back to back -> in_ready=0 after the second; third is held by the source; count=2. Assert out_ready for one cycle -> first entry popped, count=1, third accepted the following cycle. Order preserved.
5. count=2, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, fields=0, nothing pushed or popped.
6. Hold count=1 with simultaneous push and pop for 10 cycles -> count stays 1, pointers wrap, and the output sequence equals the input sequence delayed by one entry. With FIELD_SEP_PERF_EN defined, instr_cnt equals the number of pushes.
